// File: rtl/orion_clken_gen.sv
// Fractional clock-enable generator: NUM_CH Bresenham phase accumulators producing num/den
// strobes on the master clock, with a lock flag that drops around every reconfiguration.
module orion_clken_gen #(
    parameter int                          NUM_CH      = 3,
    parameter int                          ACC_W       = 16,
    parameter int                          LOCK_CYCLES = 64,
    parameter logic [NUM_CH*ACC_W-1:0]     DEF_NUM     = {16'd1, 16'd1, 16'd1},
    parameter logic [NUM_CH*ACC_W-1:0]     DEF_DEN     = {16'd1, 16'd2, 16'd8}
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic             err_q;
    logic             locked_q;

    logic cfg_fire;
    logic cfg_bad;
    logic cfg_ok;

    // A rejected request still completes the handshake; only a good one touches state.
    always_comb begin
        cfg_fire = cfg_valid & ready_q;
        cfg_bad  = ({1'b0, cfg_ch} >= 5'(NUM_CH)) | (cfg_den == '0) | (cfg_num > cfg_den);
        cfg_ok   = cfg_fire & ~cfg_bad;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= ST_RESET;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            err_q <= cfg_fire & cfg_bad;
            case (state_q)
                ST_RESET: begin
                    state_q  <= ST_LOCKING;
                    cnt_q    <= '0;
                    ready_q  <= 1'b1;
                    locked_q <= 1'b0;
                end
                ST_LOCKING: begin
                    if (cfg_ok) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= ST_LOCKED;
                        cnt_q    <= '0;
                        locked_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (cfg_ok) begin
                        state_q  <= ST_LOCKING;
                        cnt_q    <= '0;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_RESET;
                    cnt_q    <= '0;
                    ready_q  <= 1'b0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign locked    = locked_q;

    // Accumulators run only while locked, so every channel restarts phase-aligned after a lock.
    logic run;
    assign run = (state_q == ST_LOCKED) & ~cfg_ok;

    for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
        logic [ACC_W-1:0] num_q;
        logic [ACC_W-1:0] den_q;
        logic [ACC_W-1:0] acc_q;
        logic [ACC_W-1:0] acc_d;
        logic             ce_q;
        logic [ACC_W:0]   sum;
        logic [ACC_W:0]   diff;
        logic             ovf;
        logic             wr;

        always_comb begin
            sum  = {1'b0, acc_q} + {1'b0, num_q};
            diff = sum - {1'b0, den_q};
            ovf  = (sum >= {1'b0, den_q});
            acc_d = ovf ? diff[ACC_W-1:0] : sum[ACC_W-1:0];
            wr   = cfg_ok & (cfg_ch == 4'(i));
        end

        always_ff @(posedge refclk) begin
            if (rst) begin
                num_q <= DEF_NUM[i*ACC_W +: ACC_W];
                den_q <= DEF_DEN[i*ACC_W +: ACC_W];
                acc_q <= '0;
                ce_q  <= 1'b0;
            end else begin
                if (wr) begin
                    num_q <= cfg_num;
                    den_q <= cfg_den;
                end
                if (run) begin
                    acc_q <= acc_d;
                    ce_q  <= ovf;
                end else begin
                    acc_q <= '0;
                    ce_q  <= 1'b0;
                end
            end
        end

        assign ce[i] = ce_q;
    end

endmodule

// File: tb/tb_orion_clken_gen.sv
// Directed bench for orion_clken_gen: lock timing, strobe patterns, rejects, relock, reset.
module tb_orion_clken_gen;

    logic        refclk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_ch;
    logic [15:0] cfg_num;
    logic [15:0] cfg_den;
    logic        cfg_err;
    logic [2:0]  ce;
    logic        locked;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;
    int nums[3];
    int dens[3];

    orion_clken_gen dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_num   (cfg_num),
        .cfg_den   (cfg_den),
        .cfg_err   (cfg_err),
        .ce        (ce),
        .locked    (locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    function automatic logic [2:0] exp_ce(input int tt);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            if (tt >= 1 && (tt * nums[i]) / dens[i] > ((tt - 1) * nums[i]) / dens[i])
                r[i] = 1'b1;
        return r;
    endfunction

    task automatic set_defaults();
        nums = '{1, 1, 1};
        dens = '{8, 2, 1};
    endtask

    // One locked cycle: check strobes against the floor-rule model, then advance.
    task automatic step(input string tag);
        chk({tag, "_locked"}, 32'(locked), 32'd1);
        chk({tag, "_ce"}, 32'(ce), 32'(exp_ce(t)));
        tick();
        t++;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Called in the first LOCKING cycle (count 0): 64 unlocked cycles, then locked at t=0.
    task automatic wait_lock(input string tag);
        for (int m = 0; m < 64; m++) begin
            chk({tag, "_unlocked"}, 32'(locked), 32'd0);
            chk({tag, "_ce_quiet"}, 32'(ce), 32'd0);
            tick();
        end
        t = 0;
    endtask

    task automatic drive(input logic [3:0] ch, input int num, input int den);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_num   = 16'(num);
        cfg_den   = 16'(den);
    endtask

    task automatic reject(input string tag, input logic [3:0] ch, input int num, input int den);
        drive(ch, num, den);
        step(tag);
        cfg_valid = 1'b0;
        chk({tag, "_err"}, 32'(cfg_err), 32'd1);
        step(tag);
        chk({tag, "_err_clr"}, 32'(cfg_err), 32'd0);
        run(tag, 10);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_num   = '0;
        cfg_den   = '0;
        set_defaults();
        repeat (3) tick();
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);

        // Lock from reset with default ratios 1/8, 1/2, 1/1
        rst = 1'b0;
        tick();
        chk("boot_ready", 32'(cfg_ready), 32'd1);
        wait_lock("boot");
        run("dflt", 24);

        // Retune ch0 to 3/8 while locked
        drive(4'd0, 3, 8);
        step("wr0");
        cfg_valid = 1'b0;
        chk("wr0_locked_drop", 32'(locked), 32'd0);
        chk("wr0_ce_drop", 32'(ce), 32'd0);
        chk("wr0_err", 32'(cfg_err), 32'd0);
        chk("wr0_ready", 32'(cfg_ready), 32'd1);
        nums[0] = 3;
        wait_lock("wr0");
        run("r38", 24);

        // Bad requests: num>den, den=0, channel out of range
        reject("rej_nd", 4'd0, 5, 4);
        reject("rej_d0", 4'd1, 1, 0);
        reject("rej_ch", 4'd3, 1, 1);

        // Second request at lock count 40 restarts the full count
        drive(4'd1, 1, 4);
        step("mid1");
        cfg_valid = 1'b0;
        for (int m = 0; m < 40; m++) begin
            chk("mid_unlocked", 32'(locked), 32'd0);
            tick();
        end
        drive(4'd1, 0, 1);
        tick();
        cfg_valid = 1'b0;
        chk("mid2_err", 32'(cfg_err), 32'd0);
        nums[1] = 0;
        dens[1] = 1;
        wait_lock("mid2");

        // ch1 silent at 0/1 while ch0 (3/8) and ch2 (1/1) keep toggling
        run("num0", 1000);

        // Reset while locked with a valid request pending: request must be dropped
        rst = 1'b1;
        drive(4'd2, 1, 4);
        tick();
        chk("rst2_ce", 32'(ce), 32'd0);
        chk("rst2_locked", 32'(locked), 32'd0);
        chk("rst2_ready", 32'(cfg_ready), 32'd0);
        chk("rst2_err", 32'(cfg_err), 32'd0);
        rst       = 1'b0;
        cfg_valid = 1'b0;
        tick();
        chk("rst2_ready_up", 32'(cfg_ready), 32'd1);
        set_defaults();
        wait_lock("rst2");
        run("dflt2", 24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/orion_clken_gen.md
# orion_clken_gen

Parametrised, runtime-reprogrammable clock-enable generator for the ORION-NG core. From one master clock it derives NUM_CH fractional clock-enable strobes of rate num/den (phase-accumulator, Bresenham style), plus a PLL-style `locked` flag that drops and re-asserts around every reconfiguration. It sits directly behind the board PLL. It replaces the fixed-ratio extra PLL outputs: the video, CPU and peripheral domains run on the master clock, qualified by `ce`, so retuning (turbo, video mode) needs no PLL reconfiguration.

## Interface
- NUM_CH, 3, number of enable channels (1..16)
- ACC_W, 16, width of num/den/accumulator per channel
- LOCK_CYCLES, 64, master cycles from reset/reconfig to `locked` (≥1)
- DEF_NUM, {16'd1,16'd1,16'd1}, packed NUM_CH×ACC_W reset numerators (channel 0 in LSBs)
- DEF_DEN, {16'd1,16'd2,16'd8}, packed NUM_CH×ACC_W reset denominators (at 200 MHz master: ch0 = 25 MHz, ch1 = 100 MHz, ch2 = 200 MHz)

Ports:
- refclk  in  1  master clock; all logic on its rising edge
- rst  in  1  reset, synchronous and active-high
- cfg_valid  in  1  reconfiguration request
- cfg_ready  out  1  request accepted when cfg_valid & cfg_ready
- cfg_ch  in  4  target channel index
- cfg_num  in  ACC_W  new numerator
- cfg_den  in  ACC_W  new denominator
- cfg_err  out  1  one-cycle pulse: request rejected
- ce  out  NUM_CH  per-channel clock-enable strobes, registered
- locked  out  1  all strobes valid and phase-aligned

## Operation
- State machine: RESET → LOCKING → LOCKED.
  - RESET is held while rst=1.
  - LOCKING: lock counter counts 0..LOCK_CYCLES−1, then goes to LOCKED.
  - An accepted request from LOCKING or LOCKED → LOCKING, with the counter cleared.
- Per-channel registers num[i], den[i] load DEF_NUM/DEF_DEN on rst.
- Per-channel accumulator acc[i] is ACC_W bits; its sum is computed in ACC_W+1 bits.
  - Accumulators clear to 0 whenever state ≠ LOCKED.
  - In LOCKED, each cycle: s = acc+num. If s ≥ den, then acc ← s−den and ce[i] ← 1 next cycle; else acc ← s and ce[i] ← 0.
- Resulting rule: with t = locked-cycle index (t=0 is the first cycle locked=1), ce[i]=1 at t iff t≥1 and floor(t·num/den) > floor((t−1)·num/den).
- num=0: channel permanently silent, legal. num=den: ce high every cycle from t=1.
- Validation: a request is rejected if cfg_ch ≥ NUM_CH, cfg_den=0, or cfg_num > cfg_den.
  - A rejected request is still consumed by the handshake.
  - Rejection pulses cfg_err for one cycle and changes nothing: ratios, state and locked are untouched.
- Acceptance of a valid request:
  - writes num/den of that channel only;
  - restarts lock for all channels, so every strobe is phase-realigned.
- cfg_ready = 1 in LOCKING and LOCKED, 0 in RESET.

## Timing
- Reset values (cycle after any edge with rst=1): ce=0, locked=0, cfg_ready=0, cfg_err=0, acc=0, lock counter=0.
- rst dominates; a cfg_valid in the same cycle is ignored.
- First edge with rst=0 enters LOCKING, and cfg_ready=1 from that cycle.
- locked rises exactly LOCK_CYCLES cycles after the first rst=0 cycle.
- Accepted valid request at edge k:
  - locked=0 and ce=0 from cycle k+1;
  - locked re-asserts at k+1+LOCK_CYCLES.
- A request accepted during LOCKING restarts the full count.
- cfg_err is asserted in the cycle after the accepting edge.
- A back-to-back request each cycle is accepted every cycle; there is no stall state.
- ce is always 0 while locked=0, and never glitches: it is a pure register output.
- Latency: the overflow decision is made at cycle t and ce is visible at t+1. The first possible strobe is t=1.

## Test plan
- Reset with defaults, LOCK_CYCLES=64:
  - locked rises 64 cycles after rst falls;
  - ce[2] high every cycle from t=1; ce[1] at t=2,4,6…; ce[0] at t=8,16,24…
- Write ch0 num=3, den=8 while locked:
  - locked low the next cycle, high 64 cycles later;
  - ce[0] at t=3,6,8,11,14,16; ce[1] and ce[2] restart phase-aligned.
- Rejects: cfg_num=5 with cfg_den=4; cfg_den=0; cfg_ch=3.
  - each gives a one-cycle cfg_err;
  - locked stays 1 and the ce patterns continue unbroken.
- Reconfig mid-LOCKING (request at lock count 40):
  - count restarts; locked rises 64 cycles after the second acceptance.
- rst asserted while LOCKED, with cfg_valid high at the same time:
  - all outputs 0 next cycle; ratios back to defaults; the request is ignored.
- Channel with num=0, den=1: ce stays 0 for 1000 locked cycles while the other channels toggle normally.
